// File: rtl/apb_poly_perimetr.sv
// ---------------------------------------------------------------------------
// apb_poly_perimetr
//
// APB slave that holds a bank of side-length registers and, on request,
// sums them into a polygon perimeter. In rectangle mode only the first two
// sides are summed and the total is doubled. The sum is built one side per
// clock in a wide accumulator. Bits that do not fit in DATA_W raise the OVF
// status flag instead of silently wrapping.
//
// Register map (byte addresses, PADDR[7:0] decoded, PADDR[1:0] ignored):
//   0x00 + 4*i  SIDE[i]  RW   i < N_SIDES
//   0x40        CTRL     WO   bit0 START (self-clearing), bit1 RECT; reads 0
//   0x44        STATUS   RO   bit0 BUSY, bit1 DONE, bit2 OVF
//   0x48        RESULT   RO
//
// Ports:
//   PCLK     in   APB clock, all state changes on the rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data, bits above DATA_W ignored
//   PRDATA   out  read data, zero-extended from DATA_W
//   PREADY   out  low only while a RESULT read waits for the computation
//   PSLVERR  out  error response for bad addresses and illegal writes
// ---------------------------------------------------------------------------
module apb_poly_perimetr #(
  parameter int N_SIDES = 4,
  parameter int DATA_W  = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  // Five spare bits cover sixteen full-scale sides, doubled in rect mode.
  localparam int ACC_W = DATA_W + 5;
  localparam int IDX_W = 5;

  localparam logic [5:0] CTRL_WORD   = 6'h10;
  localparam logic [5:0] STATUS_WORD = 6'h11;
  localparam logic [5:0] RESULT_WORD = 6'h12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  side_q [N_SIDES];
  logic [DATA_W-1:0]  side_d [N_SIDES];
  logic [ACC_W-1:0]   accum_q, accum_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               rectMode_q, rectMode_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [5:0]         wordAddr;
  logic               isSide, isCtrl, isStatus, isResult, isMapped;
  logic               busy, accessPhase, stall, xferErr, wrAccept, startReq;
  logic [DATA_W-1:0]  addrSide, indexSide;
  logic [IDX_W-1:0]   lastIndex;
  logic [ACC_W-1:0]   accumFinal;
  logic               unusedAddr;

  // Only the word offset inside the low address byte selects a register.
  assign wordAddr   = PADDR[7:2];
  assign unusedAddr = ^{PADDR[31:8], PADDR[1:0]};

  generate
    if (DATA_W < 32) begin : g_unusedWdata
      logic unusedWdata;
      assign unusedWdata = ^PWDATA[31:DATA_W];
    end
  endgenerate

  assign isSide   = ({26'd0, wordAddr} < 32'(N_SIDES));
  assign isCtrl   = (wordAddr == CTRL_WORD);
  assign isStatus = (wordAddr == STATUS_WORD);
  assign isResult = (wordAddr == RESULT_WORD);
  assign isMapped = isSide | isCtrl | isStatus | isResult;

  assign busy        = (state_q != IDLE);
  assign accessPhase = PSEL & PENABLE;

  // A RESULT read issued mid-computation is held off until BUSY has dropped,
  // so the master always receives the finished value.
  assign stall  = accessPhase & ~PWRITE & isResult & busy;
  assign PREADY = ~stall;

  // Side and control registers are frozen while the sum is in flight.
  assign xferErr = ~isMapped
                 | (PWRITE & (isStatus | isResult))
                 | (PWRITE & busy & (isSide | isCtrl));

  assign PSLVERR  = accessPhase & xferErr & ~PRESET;
  assign wrAccept = accessPhase & PWRITE & ~xferErr;
  assign startReq = wrAccept & isCtrl & PWDATA[0];

  // The rectangle run stops after SIDE[1]; a full run visits every side.
  assign lastIndex  = rectMode_q ? IDX_W'(1) : IDX_W'(N_SIDES - 1);
  assign accumFinal = rectMode_q ? {accum_q[ACC_W-2:0], 1'b0} : accum_q;

  // Side register selected by the bus address and by the accumulate index.
  always_comb begin
    addrSide  = '0;
    indexSide = '0;
    for (int i = 0; i < N_SIDES; i++) begin
      if (wordAddr == 6'(i)) addrSide = side_q[i];
      if (index_q == IDX_W'(i)) indexSide = side_q[i];
    end
  end

  // Read data is driven during both APB phases of a read and is zero for
  // writes, unmapped addresses and the write-only CTRL register.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && !PRESET) begin
      if (isSide)        PRDATA = 32'(addrSide);
      else if (isStatus) PRDATA = {29'd0, ovf_q, done_q, busy};
      else if (isResult) PRDATA = 32'(result_q);
    end
  end

  // Next-state logic: register writes plus the IDLE -> ACCUM -> FINAL walk.
  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    accum_d    = accum_q;
    index_d    = index_q;
    rectMode_d = rectMode_q;
    result_d   = result_q;
    done_d     = done_q;
    ovf_d      = ovf_q;

    for (int i = 0; i < N_SIDES; i++) begin
      if (wrAccept && isSide && (wordAddr == 6'(i))) begin
        side_d[i] = PWDATA[DATA_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (startReq) begin
          state_d    = ACCUM;
          accum_d    = '0;
          index_d    = '0;
          rectMode_d = PWDATA[1];
          done_d     = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      ACCUM: begin
        accum_d = accum_q + ACC_W'(indexSide);
        index_d = index_q + IDX_W'(1);
        if (index_q == lastIndex) state_d = FINAL;
      end
      FINAL: begin
        result_d = accumFinal[DATA_W-1:0];
        ovf_d    = |accumFinal[ACC_W-1:DATA_W];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any computation in progress.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      accum_q    <= '0;
      index_q    <= '0;
      rectMode_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < N_SIDES; i++) side_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      accum_q    <= accum_d;
      index_q    <= index_d;
      rectMode_q <= rectMode_d;
      result_q   <= result_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < N_SIDES; i++) side_q[i] <= side_d[i];
    end
  end

endmodule
